// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared types and helpers for the sipo_deser serial-to-parallel receiver.
//   state_t    : receiver FSM states (PARITY only reachable when the
//                SIPO_PARITY_CHECK_EN build option is defined)
//   cnt_width  : width of a bit counter that must hold values 0..depth
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // The bit counter reaches n, so it needs one more code than n-1.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : sipo_pkg

// File: rtl/sipo_if.sv
// -----------------------------------------------------------------------------
// sipo_if
// Bundles the serial input side and the parallel valid/ready output side of
// sipo_deser.
//   master : the environment (serial source + word consumer)
//            drives start, ser_en, ser_in, out_ready
//   slave  : the receiver; drives par_out, par_valid, busy, overrun
//            (and parity_err when SIPO_PARITY_CHECK_EN is defined)
// Parameter n is the word width and must match the receiver's n.
// -----------------------------------------------------------------------------
interface sipo_if #(
    parameter int n = 4
);
    logic         start;
    logic         ser_en;
    logic         ser_in;
    logic         out_ready;
    logic [n-1:0] par_out;
    logic         par_valid;
    logic         busy;
    logic         overrun;
`ifdef SIPO_PARITY_CHECK_EN
    logic         parity_err;
`endif

    modport master (
`ifdef SIPO_PARITY_CHECK_EN
        input  parity_err,
`endif
        output start,
        output ser_en,
        output ser_in,
        output out_ready,
        input  par_out,
        input  par_valid,
        input  busy,
        input  overrun
    );

    modport slave (
`ifdef SIPO_PARITY_CHECK_EN
        output parity_err,
`endif
        input  start,
        input  ser_en,
        input  ser_in,
        input  out_ready,
        output par_out,
        output par_valid,
        output busy,
        output overrun
    );

endinterface : sipo_if

// File: rtl/sipo_hold_buf.sv
// -----------------------------------------------------------------------------
// sipo_hold_buf
// Single-entry output holding register for sipo_deser.
//   clk, reset   : clock, synchronous active-high reset
//   load, word   : a completed word is offered on this edge
//   load_perr    : parity result for that word (SIPO_PARITY_CHECK_EN only)
//   out_ready    : consumer accepts par_out this cycle
//   par_out      : held word, stable while par_valid=1 and not taken
//   par_valid    : par_out holds an unconsumed word
//   overrun      : sticky, set when a word is offered while the entry is
//                  full and not being emptied on the same edge
//   parity_err   : parity result of the held word (SIPO_PARITY_CHECK_EN only)
// -----------------------------------------------------------------------------
module sipo_hold_buf #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] word,
`ifdef SIPO_PARITY_CHECK_EN
    input  logic         load_perr,
    output logic         parity_err,
`endif
    input  logic         out_ready,
    output logic [n-1:0] par_out,
    output logic         par_valid,
    output logic         overrun
);

    logic take;
    logic room;

    assign take = par_valid && out_ready;
    // The entry can accept a new word if it is empty or drained this edge.
    assign room = !par_valid || out_ready;

    // NOTE: reset is sampled on the clock edge only (synchronous), so it sits
    // inside the clocked block as the first priority branch, not in the
    // sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_out    <= '0;
            par_valid  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else if (load && room) begin
            par_out    <= word;
            par_valid  <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
            parity_err <= load_perr;
`endif
        end else begin
            // A word arriving with no room is lost; par_out is left alone.
            if (load) begin
                overrun <= 1'b1;
            end
            if (take) begin
                par_valid <= 1'b0;
            end
        end
    end

endmodule : sipo_hold_buf

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-to-parallel frame receiver. Reassembles LSB-first serial frames of
// n bits into words and presents each on a one-entry valid/ready output.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : sipo_if.slave
//            start/ser_en/ser_in : serial input, start marks bit 0
//            out_ready           : consumer handshake
//            par_out/par_valid   : assembled word and its valid flag
//            busy                : frame in progress
//            overrun             : sticky word-dropped flag
//            parity_err          : only with SIPO_PARITY_CHECK_EN
// Build option: define SIPO_PARITY_CHECK_EN to add a trailing even-parity bit
// per frame (PARITY state) and the parity_err output.
// -----------------------------------------------------------------------------
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int n = 4
) (
    input  logic   clk,
    input  logic   reset,
    sipo_if.slave  bus
);

    localparam int             CW       = cnt_width(n);
    localparam logic [CW-1:0]  LAST_CNT = CW'(n);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [n-1:0]  sreg;
    logic          busy_q;

    logic [n-1:0]  shifted;
    logic [CW-1:0] nxt_cnt;
    logic          bit_take;
    logic          data_done;
    logic          load;
    logic [n-1:0]  word;

    // New bit enters at the MSB; after n bits the first one sits at bit 0.
    if (n == 1) begin : g_shift_one
        assign shifted = bus.ser_in;
    end else begin : g_shift_wide
        assign shifted = {bus.ser_in, sreg[n-1:1]};
    end

    // A data bit is taken on any strobe carrying start (new frame or abort
    // and restart) or any plain strobe while shifting.
    assign bit_take  = bus.ser_en && (bus.start || state == SHIFT);
    assign nxt_cnt   = bus.start ? CW'(1) : cnt + CW'(1);
    assign data_done = bit_take && (nxt_cnt == LAST_CNT);

`ifdef SIPO_PARITY_CHECK_EN
    logic par_take;
    logic load_perr;

    assign par_take  = bus.ser_en && !bus.start && (state == PARITY);
    assign load      = par_take;
    assign word      = sreg;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign load_perr = ^{sreg, bus.ser_in};
`else
    logic unused_sreg_lsb;

    // The oldest bit is shifted out on the completing edge and never read.
    assign unused_sreg_lsb = sreg[0];
    assign load            = data_done;
    assign word            = shifted;
`endif

    // NOTE: all state in clocked blocks uses non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            busy_q <= 1'b0;
        end else if (bit_take) begin
            sreg <= shifted;
            if (data_done) begin
`ifdef SIPO_PARITY_CHECK_EN
                state  <= PARITY;
                cnt    <= nxt_cnt;
                busy_q <= 1'b1;
`else
                state  <= IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
`endif
            end else begin
                state  <= SHIFT;
                cnt    <= nxt_cnt;
                busy_q <= 1'b1;
            end
        end
`ifdef SIPO_PARITY_CHECK_EN
        else if (par_take) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end
`endif
    end

    assign bus.busy = busy_q;

    sipo_hold_buf #(
        .n (n)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .word       (word),
`ifdef SIPO_PARITY_CHECK_EN
        .load_perr  (load_perr),
        .parity_err (bus.parity_err),
`endif
        .out_ready  (bus.out_ready),
        .par_out    (bus.par_out),
        .par_valid  (bus.par_valid),
        .overrun    (bus.overrun)
    );

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Directed bench for sipo_deser with n=4 (default build, no parity bit).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    sipo_if #(.n(4)) bus ();

    sipo_deser #(.n(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start  = 1'b0;
        bus.ser_en = 1'b0;
        bus.ser_in = 1'b0;
    endtask

    task automatic send_bit(input logic st, input logic b);
        bus.start  = st;
        bus.ser_en = 1'b1;
        bus.ser_in = b;
        step();
    endtask

    task automatic send_frame(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            send_bit(i == 0, w[i]);
        end
        idle_in();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_in();
        step();
        tests_run++;
        if (bus.par_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_par_out: got %h want 0", bus.par_out);
        end
        tests_run++;
        if ({bus.par_valid, bus.busy, bus.overrun} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid/busy/ovr=%b want 000",
                     {bus.par_valid, bus.busy, bus.overrun});
        end
        reset = 1'b0;
        // Strobes without start must not begin a frame.
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0, 1'b1);
        end
        idle_in();
        tests_run++;
        if ({bus.busy, bus.par_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL no_start_ignored: got busy/valid=%b want 00",
                     {bus.busy, bus.par_valid});
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        tests_run++;
        if ({bus.busy, bus.par_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_first_bit: got busy/valid=%b want 10",
                     {bus.busy, bus.par_valid});
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        idle_in();
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'hB) begin
            tests_failed++;
            $display("FAIL basic_word: got valid=%b out=%h want 1 b",
                     bus.par_valid, bus.par_out);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_done: got %b want 0", bus.busy);
        end
        step();
        tests_run++;
        if (bus.par_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_one_cycle: got valid=%b want 0", bus.par_valid);
        end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({bus.busy, bus.par_valid} !== 2'b10) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got busy/valid=%b want 10",
                         i, {bus.busy, bus.par_valid});
            end
        end
        send_bit(1'b0, 1'b0);
        idle_in();
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'h6) begin
            tests_failed++;
            $display("FAIL stall_word: got valid=%b out=%h want 1 6",
                     bus.par_valid, bus.par_out);
        end
        step();
    endtask

    task automatic test_overrun();
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(4'hA);
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'hA || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_first: got valid=%b out=%h ovr=%b want 1 a 0",
                     bus.par_valid, bus.par_out, bus.overrun);
        end
        send_frame(4'h5);
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'hA) begin
            tests_failed++;
            $display("FAIL ovr_hold: got valid=%b out=%h want 1 a",
                     bus.par_valid, bus.par_out);
        end
        tests_run++;
        if (bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_flag: got %b want 1", bus.overrun);
        end
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (bus.par_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_sticky: got valid=%b ovr=%b want 0 1",
                     bus.par_valid, bus.overrun);
        end
    endtask

    task automatic test_same_edge();
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(4'h3);
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'h3) begin
            tests_failed++;
            $display("FAIL same_first: got valid=%b out=%h want 1 3",
                     bus.par_valid, bus.par_out);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        tests_run++;
        if (bus.par_out !== 4'h3) begin
            tests_failed++;
            $display("FAIL same_stable: got out=%h want 3", bus.par_out);
        end
        bus.out_ready = 1'b1;
        send_bit(1'b0, 1'b1);
        idle_in();
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'hC || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_edge: got valid=%b out=%h ovr=%b want 1 c 0",
                     bus.par_valid, bus.par_out, bus.overrun);
        end
        step();
        tests_run++;
        if (bus.par_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_drain: got valid=%b want 0", bus.par_valid);
        end
    endtask

    task automatic test_restart();
        int pulses;
        pulses = 0;
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        pulses += int'(bus.par_valid);
        send_bit(1'b0, 1'b1);
        pulses += int'(bus.par_valid);
        send_bit(1'b1, 1'b1);
        pulses += int'(bus.par_valid);
        send_bit(1'b0, 1'b0);
        pulses += int'(bus.par_valid);
        send_bit(1'b0, 1'b0);
        pulses += int'(bus.par_valid);
        send_bit(1'b0, 1'b0);
        idle_in();
        pulses += int'(bus.par_valid);
        tests_run++;
        if (bus.par_out !== 4'h1) begin
            tests_failed++;
            $display("FAIL restart_word: got out=%h want 1", bus.par_out);
        end
        step();
        pulses += int'(bus.par_valid);
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL restart_pulses: got %0d want 1", pulses);
        end
        tests_run++;
        if (bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_no_ovr: got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        reset = 1'b1;
        idle_in();
        step();
        tests_run++;
        if (bus.par_out !== 4'h0 ||
            {bus.par_valid, bus.busy, bus.overrun} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset: got out=%h valid/busy/ovr=%b want 0 000",
                     bus.par_out, {bus.par_valid, bus.busy, bus.overrun});
        end
        reset = 1'b0;
        send_frame(4'hF);
        tests_run++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== 4'hF) begin
            tests_failed++;
            $display("FAIL midreset_frame: got valid=%b out=%h want 1 f",
                     bus.par_valid, bus.par_out);
        end
        step();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        idle_in();
        step();
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_same_edge();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sipo_deser
